// File: rtl/ctrl_seq.sv
// ----------------------------------------------------------------------------
// ctrl_seq -- registered, sequenced instruction-control decoder.
//
// Takes opcode/op_ext words from fetch through a valid/ready handshake and
// presents a registered control bundle to execute one cycle later. Issue
// stalls are inserted after control transfers and memory ops, a sticky
// HALTED state is entered on HALT, and output handshakes are counted.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid / in_ready      upstream handshake
//   in_opcode, in_op_ext     instruction word
//   flush                    drop held bundle and any pending stall
//   resume                   one-cycle pulse that leaves HALTED
//   out_valid / out_ready    downstream handshake
//   dec_*                    registered control bundle
//   halted                   state is HALTED
//   retired                  count of output handshakes (wraps)
// ----------------------------------------------------------------------------
module ctrl_seq #(
   parameter int EXT_W      = 2,
   parameter int BR_BUBBLES = 2,
   parameter int MEM_LAT    = 3,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         in_opcode,
   input  logic [EXT_W-1:0]   in_op_ext,
   input  logic               flush,
   input  logic               resume,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2:0]         dec_class,
   output logic [1:0]         dec_cond,
   output logic               dec_jump_reg,
   output logic [EXT_W+2:0]   dec_alu_func,
   output logic               dec_reg_write,
   output logic               dec_mem_read,
   output logic               dec_mem_write,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   typedef enum logic [2:0] {
      CLS_NOP, CLS_HALT, CLS_JUMP, CLS_BRANCH,
      CLS_ALU_RR, CLS_ALU_IMM, CLS_LOAD, CLS_STORE
   } cls_e;

   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_HALTED} state_e;

   typedef struct packed {
      cls_e               cls;
      logic [1:0]         cond;
      logic               jump_reg;
      logic [EXT_W+2:0]   alu_func;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
   } bundle_t;

   // The stall counter only ever holds N-1, so log2 of the larger bubble
   // count is enough bits.
   localparam int STALL_MAX = (BR_BUBBLES > MEM_LAT) ? BR_BUBBLES : MEM_LAT;
   localparam int SC_W      = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
   localparam logic [SC_W-1:0] BR_INIT  = SC_W'((BR_BUBBLES > 0) ? BR_BUBBLES - 1 : 0);
   localparam logic [SC_W-1:0] MEM_INIT = SC_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

   state_e            state_q, state_d;
   logic [SC_W-1:0]   cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   bundle_t           bundle_q, bundle_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   bundle_t           dec_w;
   logic              accept;
   logic              out_hs;

   // Pure decode of the incoming word; only ever sampled into bundle_q,
   // so there is no combinational path from in_opcode to an output.
   // NOTE: every field gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      dec_w = '0;
      unique case (in_opcode[4:3])
         2'b00: begin
            if (in_opcode[2]) begin
               dec_w.cls      = CLS_JUMP;
               dec_w.jump_reg = in_opcode[0];
            end else if (in_opcode[2:0] == 3'b000) begin
               dec_w.cls = CLS_HALT;
            end
         end
         2'b01: begin
            if (in_opcode[2]) begin
               dec_w.cls  = CLS_BRANCH;
               dec_w.cond = in_opcode[1:0];
            end else begin
               dec_w.cls       = CLS_ALU_IMM;
               dec_w.alu_func  = {{EXT_W{1'b0}}, in_opcode[2:0]};
               dec_w.reg_write = 1'b1;
            end
         end
         2'b10: begin
            if (in_opcode[2:0] == 3'b000) begin
               dec_w.cls       = CLS_LOAD;
               dec_w.reg_write = 1'b1;
               dec_w.mem_read  = 1'b1;
            end else if (in_opcode[2:0] == 3'b001) begin
               dec_w.cls       = CLS_STORE;
               dec_w.mem_write = 1'b1;
            end else begin
               dec_w.cls       = CLS_ALU_IMM;
               dec_w.alu_func  = {{EXT_W{1'b0}}, in_opcode[2:0]};
               dec_w.reg_write = 1'b1;
            end
         end
         default: begin
            dec_w.cls       = CLS_ALU_RR;
            dec_w.alu_func  = {in_op_ext, in_opcode[2:0]};
            dec_w.reg_write = 1'b1;
         end
      endcase
   end

   assign in_ready = (state_q == ST_RUN) && !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      // A bundle dropped by flush was never delivered, so it is not retired.
      retired_d   = (out_hs && !flush) ? retired_q + CNT_W'(1) : retired_q;

      if (flush) begin
         // in_ready is low under flush, so no accept can happen here.
         out_valid_d = 1'b0;
         cnt_d       = '0;
         if (state_q == ST_STALL || (state_q == ST_HALTED && resume)) begin
            state_d = ST_RUN;
         end
      end else begin
         if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec_w;
         end else if (out_hs) begin
            out_valid_d = 1'b0;
         end

         unique case (state_q)
            ST_RUN: begin
               if (accept) begin
                  if ((dec_w.cls == CLS_JUMP || dec_w.cls == CLS_BRANCH) && BR_BUBBLES > 0) begin
                     state_d = ST_STALL;
                     cnt_d   = BR_INIT;
                  end else if ((dec_w.cls == CLS_LOAD || dec_w.cls == CLS_STORE) && MEM_LAT > 0) begin
                     state_d = ST_STALL;
                     cnt_d   = MEM_INIT;
                  end else if (dec_w.cls == CLS_HALT) begin
                     state_d = ST_HALTED;
                  end
               end
            end
            ST_STALL: begin
               if (cnt_q == '0) state_d = ST_RUN;
               else             cnt_d   = cnt_q - SC_W'(1);
            end
            ST_HALTED: begin
               if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
         retired_q   <= retired_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign dec_class     = bundle_q.cls;
   assign dec_cond      = bundle_q.cond;
   assign dec_jump_reg  = bundle_q.jump_reg;
   assign dec_alu_func  = bundle_q.alu_func;
   assign dec_reg_write = bundle_q.reg_write;
   assign dec_mem_read  = bundle_q.mem_read;
   assign dec_mem_write = bundle_q.mem_write;
   assign halted        = (state_q == ST_HALTED);
   assign retired       = retired_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// ----------------------------------------------------------------------------
// tb_ctrl_seq -- self-checking bench for ctrl_seq.
// Table of decode vectors with hand-computed bundles, followed by directed
// sequences for stalls, back-pressure, halt/resume, flush, counter wrap and
// asynchronous reset. Inputs are driven and outputs sampled on the falling
// edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_ctrl_seq;

   localparam int EXT_W = 2;
   localparam int CNT_W = 4;
   localparam int AW    = EXT_W + 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_ready;
   logic [4:0]         in_opcode;
   logic [EXT_W-1:0]   in_op_ext;
   logic               flush, resume;
   logic               out_valid, out_ready;
   logic [2:0]         dec_class;
   logic [1:0]         dec_cond;
   logic               dec_jump_reg;
   logic [AW-1:0]      dec_alu_func;
   logic               dec_reg_write, dec_mem_read, dec_mem_write;
   logic               halted;
   logic [CNT_W-1:0]   retired;

   ctrl_seq #(.EXT_W(EXT_W), .BR_BUBBLES(2), .MEM_LAT(3), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_op_ext(in_op_ext),
      .flush(flush), .resume(resume),
      .out_valid(out_valid), .out_ready(out_ready),
      .dec_class(dec_class), .dec_cond(dec_cond), .dec_jump_reg(dec_jump_reg),
      .dec_alu_func(dec_alu_func), .dec_reg_write(dec_reg_write),
      .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
      .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [4:0] opc;
      logic [1:0] ext;
      logic [2:0] cls;
      logic [1:0] cond;
      logic       jr;
      logic [4:0] alu;
      logic       rw;
      logic       mr;
      logic       mw;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {out_valid, halted, class, cond, jump_reg, alu_func, rw, mr, mw}
   function automatic logic [15:0] act_pack();
      return {out_valid, halted, dec_class, dec_cond, dec_jump_reg,
              dec_alu_func, dec_reg_write, dec_mem_read, dec_mem_write};
   endfunction

   function automatic logic [15:0] exp_pack(input vec_t v);
      return {1'b1, (v.cls == 3'd1), v.cls, v.cond, v.jr, v.alu, v.rw, v.mr, v.mw};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_opcode = '0; in_op_ext = '0;
      flush = 1'b0; resume = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // Present one word for one rising edge; returns on the following falling
   // edge with the registered bundle visible.
   task automatic issue(input logic [4:0] opc, input logic [1:0] ext);
      in_valid  = 1'b1;
      in_opcode = opc;
      in_op_ext = ext;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_vec", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      //          opc       ext    cls   cond  jr  alu       rw mr mw
      vecs[0]  = '{5'b11010, 2'b01, 3'd4, 2'd0, 0, 5'b01010, 1, 0, 0};
      vecs[1]  = '{5'b01110, 2'b11, 3'd3, 2'd2, 0, 5'b00000, 0, 0, 0};
      vecs[2]  = '{5'b00101, 2'b00, 3'd2, 2'd0, 1, 5'b00000, 0, 0, 0};
      vecs[3]  = '{5'b00100, 2'b01, 3'd2, 2'd0, 0, 5'b00000, 0, 0, 0};
      vecs[4]  = '{5'b00000, 2'b00, 3'd1, 2'd0, 0, 5'b00000, 0, 0, 0};
      vecs[5]  = '{5'b00011, 2'b11, 3'd0, 2'd0, 0, 5'b00000, 0, 0, 0};
      vecs[6]  = '{5'b01001, 2'b11, 3'd5, 2'd0, 0, 5'b00001, 1, 0, 0};
      vecs[7]  = '{5'b10000, 2'b10, 3'd6, 2'd0, 0, 5'b00000, 1, 1, 0};
      vecs[8]  = '{5'b10001, 2'b00, 3'd7, 2'd0, 0, 5'b00000, 0, 0, 1};
      vecs[9]  = '{5'b10110, 2'b10, 3'd5, 2'd0, 0, 5'b00110, 1, 0, 0};
      vecs[10] = '{5'b11111, 2'b11, 3'd4, 2'd0, 0, 5'b11111, 1, 0, 0};
      vecs[11] = '{5'b01111, 2'b00, 3'd3, 2'd3, 0, 5'b00000, 0, 0, 0};

      // Reset state
      do_reset();
      check("rst_outputs",  {16'd0, act_pack()}, 32'd0);
      check("rst_retired",  {28'd0, retired}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // First ALU_RR: one-cycle latency, then one retirement
      out_ready = 1'b1;
      issue(5'b11010, 2'b01);
      check("alu_rr_bundle", {16'd0, act_pack()}, {16'd0, exp_pack(vecs[0])});
      @(negedge clk);
      check("alu_rr_retired", {28'd0, retired}, 32'd1);
      check("alu_rr_drained", {31'd0, out_valid}, 32'd0);

      // Decode table
      for (int i = 0; i < 12; i++) begin
         wait_ready();
         issue(vecs[i].opc, vecs[i].ext);
         check($sformatf("vec%0d_op%b", i, vecs[i].opc), {16'd0, act_pack()},
               {16'd0, exp_pack(vecs[i])});
         if (vecs[i].cls == 3'd1) begin
            resume = 1'b1;
            @(negedge clk);
            resume = 1'b0;
         end
      end

      // BRANCH: exactly two cycles of in_ready=0
      do_reset();
      out_ready = 1'b1;
      issue(5'b01110, 2'b00);
      check("br_cond",   {30'd0, dec_cond}, 32'd2);
      check("br_stall1", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("br_stall2", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("br_ready",  {31'd0, in_ready}, 32'd1);

      // LOAD under back-pressure: held stable, retired exactly once
      do_reset();
      out_ready = 1'b0;
      issue(5'b10000, 2'b00);
      for (int k = 0; k < 4; k++) begin
         check("ld_hold",        {16'd0, act_pack()}, {16'd0, exp_pack('{5'b10000, 2'b00, 3'd6, 2'd0, 0, 5'b0, 1, 1, 0})});
         check("ld_in_ready",    {31'd0, in_ready}, 32'd0);
         check("ld_retired_hold", {28'd0, retired}, 32'd0);
         if (k < 3) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("ld_retired_once", {28'd0, retired}, 32'd1);
      check("ld_drained",      {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("ld_retired_stay", {28'd0, retired}, 32'd1);

      // HALT: sticky while in_valid stays high, resume releases
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_opcode = 5'b00000;
      in_op_ext = 2'b00;
      @(negedge clk);
      check("halt_bundle", {16'd0, act_pack()}, {16'd0, exp_pack(vecs[4])});
      in_opcode = 5'b11000;
      for (int k = 0; k < 10; k++) begin
         check("halt_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      check("halt_halted",  {31'd0, halted}, 32'd1);
      check("halt_retired", {28'd0, retired}, 32'd1);
      check("halt_drained", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;
      resume   = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      #1;
      check("resume_in_ready", {31'd0, in_ready}, 32'd1);
      check("resume_halted",   {31'd0, halted}, 32'd0);

      // flush together with resume in HALTED
      out_ready = 1'b0;
      issue(5'b00000, 2'b00);
      check("fr_halted_pre", {31'd0, halted}, 32'd1);
      flush  = 1'b1;
      resume = 1'b1;
      @(negedge clk);
      flush  = 1'b0;
      resume = 1'b0;
      #1;
      check("fr_halted",    {31'd0, halted}, 32'd0);
      check("fr_out_valid", {31'd0, out_valid}, 32'd0);
      check("fr_in_ready",  {31'd0, in_ready}, 32'd1);
      check("fr_retired",   {28'd0, retired}, 32'd1);

      // flush during MEM_LAT stall while the bundle is being taken
      do_reset();
      out_ready = 1'b1;
      issue(5'b10001, 2'b00);
      check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("fl_out_valid", {31'd0, out_valid}, 32'd0);
      check("fl_in_ready",  {31'd0, in_ready}, 32'd1);
      check("fl_retired",   {28'd0, retired}, 32'd0);

      // 16 back-to-back ALU handshakes: retired 15 then wraps to 0
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_opcode = 5'b11000;
      in_op_ext = 2'b00;
      repeat (16) @(negedge clk);
      check("wrap_15", {28'd0, retired}, 32'd15);
      in_valid = 1'b0;
      @(negedge clk);
      check("wrap_0",  {28'd0, retired}, 32'd0);

      // Asynchronous reset mid-stall
      do_reset();
      out_ready = 1'b1;
      issue(5'b11000, 2'b00);
      @(negedge clk);
      issue(5'b00100, 2'b00);
      check("ars_pre_retired", {28'd0, retired}, 32'd1);
      check("ars_pre_stall",   {31'd0, in_ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("ars_outputs", {16'd0, act_pack()}, 32'd0);
      check("ars_retired", {28'd0, retired}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-halt
      #1;
      issue(5'b00000, 2'b00);
      check("arh_pre_halted", {31'd0, halted}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arh_outputs", {16'd0, act_pack()}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
